rv_mem_arb: RTL and testbench

- Sequences and shares the single-port data/instruction memory of the multicycle RISC-V core between two requesters: the core (port C) and a DMA/program loader (port D).
- Accepts one request at a time, drives the memory for the configured read latency, and returns a one-cycle done pulse with read data.
- The core control FSM holds its FETCH/LW_MEM/SW_MEM states until core_done.
- Includes a core-stall cycle counter for performance checks.

---
 rtl/rv_mem_arb.sv | 119 +++++++++++
 tb/tb_rv_mem_arb.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_arb.sv
// Shares the single-port memory of the multicycle RISC-V core between the core
// and a DMA/program loader: one access at a time, fixed read latency, done pulse.
module rv_mem_arb #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned CORE_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_done,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       stall_cnt
);

  localparam int unsigned LAT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic               owner;     // 0 = core, 1 = dma
  logic               we_q;
  logic [LAT_W-1:0]   lat_cnt;
  logic               grant;
  logic               win;
  logic               fin;

  // Arbitration among requests sampled in IDLE; ties go to the non-owner unless the core has priority
  always_comb begin
    grant = 1'b0;
    win   = 1'b0;
    if (state == IDLE) begin
      if (core_req && dma_req) begin
        grant = 1'b1;
        win   = (CORE_PRIO != 0) ? 1'b0 : ~owner;
      end else if (core_req) begin
        grant = 1'b1;
        win   = 1'b0;
      end else if (dma_req) begin
        grant = 1'b1;
        win   = 1'b1;
      end
    end
  end

  assign fin = (state == WAIT) && (lat_cnt == LAT_W'(MEM_LAT));

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (fin) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Latched request, memory strobes, latency counter and stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= 1'b1;
      we_q      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      mem_en <= grant;
      mem_we <= grant & (win ? dma_we : core_we);
      if (grant) begin
        owner     <= win;
        we_q      <= win ? dma_we : core_we;
        mem_addr  <= win ? dma_addr : core_addr;
        mem_wdata <= win ? dma_wdata : core_wdata;
      end
      if (state == ISSUE) begin
        lat_cnt <= LAT_W'(1);
      end else if ((state == WAIT) && (lat_cnt < LAT_W'(MEM_LAT))) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end
      if (core_req && !core_done) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Done and read data are decoded from the finishing WAIT cycle; read data passes straight through
  assign core_done  = fin & ~owner;
  assign dma_done   = fin & owner;
  assign core_rdata = (core_done && !we_q) ? mem_rdata : '0;
  assign dma_rdata  = (dma_done && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Bench for rv_mem_arb: two configurations (MEM_LAT=3 round-robin, MEM_LAT=1 core
// priority) checked every cycle against a timestamp-based transaction model.
module tb_rv_mem_arb;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int          LAT0 = 3;
  localparam int          LAT1 = 1;

  logic          clk;
  logic          rst;
  logic          core_req   [2];
  logic          core_we    [2];
  logic [31:0]   core_addr  [2];
  logic [31:0]   core_wdata [2];
  logic          core_done  [2];
  logic [31:0]   core_rdata [2];
  logic          dma_req    [2];
  logic          dma_we     [2];
  logic [31:0]   dma_addr   [2];
  logic [31:0]   dma_wdata  [2];
  logic          dma_done   [2];
  logic [31:0]   dma_rdata  [2];
  logic          mem_en     [2];
  logic          mem_we     [2];
  logic [31:0]   mem_addr   [2];
  logic [31:0]   mem_wdata  [2];
  logic [31:0]   mem_rdata  [2];
  logic [31:0]   stall_cnt  [2];

  rv_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT0), .CORE_PRIO(0)) dut0 (
    .clk(clk), .rst(rst),
    .core_req(core_req[0]), .core_we(core_we[0]), .core_addr(core_addr[0]),
    .core_wdata(core_wdata[0]), .core_done(core_done[0]), .core_rdata(core_rdata[0]),
    .dma_req(dma_req[0]), .dma_we(dma_we[0]), .dma_addr(dma_addr[0]),
    .dma_wdata(dma_wdata[0]), .dma_done(dma_done[0]), .dma_rdata(dma_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .stall_cnt(stall_cnt[0])
  );

  rv_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT1), .CORE_PRIO(1)) dut1 (
    .clk(clk), .rst(rst),
    .core_req(core_req[1]), .core_we(core_we[1]), .core_addr(core_addr[1]),
    .core_wdata(core_wdata[1]), .core_done(core_done[1]), .core_rdata(core_rdata[1]),
    .dma_req(dma_req[1]), .dma_we(dma_we[1]), .dma_addr(dma_addr[1]),
    .dma_wdata(dma_wdata[1]), .dma_done(dma_done[1]), .dma_rdata(dma_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .stall_cnt(stall_cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int cyc;

  // Memory behind each arbiter plus its read-return pipeline (slot = return cycle mod 8)
  logic [31:0] bmem [2][64];
  logic        pv   [2][8];
  logic [31:0] pd   [2][8];

  // Reference model: the next free grant cycle, issue/done cycle stamps, and a shadow memory
  int          free_c  [2];
  int          iss_c   [2];
  int          done_c  [2];
  logic        dport   [2];
  logic        dwe     [2];
  logic [31:0] drd     [2];
  logic        own     [2];
  logic        iss_we  [2];
  logic [31:0] lat_addr[2];
  logic [31:0] lat_wd  [2];
  logic [31:0] stall   [2];
  logic [31:0] mmem    [2][64];
  logic        m_cd    [2];
  logic        m_dd    [2];

  // DUT outputs seen in the most recently sampled cycle
  logic        obs_cd [2];
  logic        obs_dd [2];
  logic [31:0] obs_cr [2];
  logic [31:0] obs_dr [2];
  logic        obs_me [2];
  logic [31:0] obs_ma [2];
  logic [31:0] obs_st [2];

  typedef struct {
    int          inst;
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_lat;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [8];

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int i);
    free_c[i]   = 0;
    iss_c[i]    = -10;
    done_c[i]   = -10;
    dport[i]    = 1'b0;
    dwe[i]      = 1'b0;
    drd[i]      = '0;
    own[i]      = 1'b1;
    iss_we[i]   = 1'b0;
    lat_addr[i] = '0;
    lat_wd[i]   = '0;
    stall[i]    = '0;
    for (int s = 0; s < 8; s++) pv[i][s] = 1'b0;
  endtask

  // Compare one cycle of both DUTs against the model, then advance the model
  task automatic model_cycle();
    logic        ecd, edd, eme, emw, w, both;
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      if (rst) model_reset(i);
      ecd = (cyc == done_c[i]) && !dport[i];
      edd = (cyc == done_c[i]) && dport[i];
      eme = (cyc == iss_c[i]);
      emw = eme && iss_we[i];
      chk($sformatf("u%0d core_done", i), 32'(core_done[i]), 32'(ecd));
      chk($sformatf("u%0d dma_done", i), 32'(dma_done[i]), 32'(edd));
      chk($sformatf("u%0d core_rdata", i), core_rdata[i], (ecd && !dwe[i]) ? drd[i] : 32'h0);
      chk($sformatf("u%0d dma_rdata", i), dma_rdata[i], (edd && !dwe[i]) ? drd[i] : 32'h0);
      chk($sformatf("u%0d mem_en", i), 32'(mem_en[i]), 32'(eme));
      chk($sformatf("u%0d mem_we", i), 32'(mem_we[i]), 32'(emw));
      chk($sformatf("u%0d mem_addr", i), mem_addr[i], lat_addr[i]);
      chk($sformatf("u%0d mem_wdata", i), mem_wdata[i], lat_wd[i]);
      chk($sformatf("u%0d stall_cnt", i), stall_cnt[i], stall[i]);
      m_cd[i]   = ecd;
      m_dd[i]   = edd;
      obs_cd[i] = core_done[i];
      obs_dd[i] = dma_done[i];
      obs_cr[i] = core_rdata[i];
      obs_dr[i] = dma_rdata[i];
      obs_me[i] = mem_en[i];
      obs_ma[i] = mem_addr[i];
      obs_st[i] = stall_cnt[i];
      // Memory environment follows what the DUT actually drives
      if (!rst && mem_en[i]) begin
        if (mem_we[i]) begin
          bmem[i][mem_addr[i][7:2]] = mem_wdata[i];
        end else begin
          pv[i][(cyc + lat_of(i)) % 8] = 1'b1;
          pd[i][(cyc + lat_of(i)) % 8] = bmem[i][mem_addr[i][7:2]];
        end
      end
      if (!rst) begin
        if (core_req[i] && !ecd) stall[i] = stall[i] + 32'd1;
        if (cyc >= free_c[i] && (core_req[i] || dma_req[i])) begin
          both = core_req[i] && dma_req[i];
          if (both) w = (i == 1) ? 1'b0 : !own[i];
          else      w = dma_req[i];
          own[i]      = w;
          dport[i]    = w;
          iss_c[i]    = cyc + 1;
          done_c[i]   = cyc + 1 + lat_of(i);
          free_c[i]   = cyc + 2 + lat_of(i);
          dwe[i]      = w ? dma_we[i] : core_we[i];
          a           = w ? dma_addr[i] : core_addr[i];
          lat_addr[i] = a;
          lat_wd[i]   = w ? dma_wdata[i] : core_wdata[i];
          iss_we[i]   = dwe[i];
          drd[i]      = dwe[i] ? 32'h0 : mmem[i][a[7:2]];
          if (dwe[i]) mmem[i][a[7:2]] = lat_wd[i];
        end
      end
    end
  endtask

  // Sample the current cycle at the falling edge, then move to the next cycle
  task automatic cycle();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      mem_rdata[i] = pv[i][cyc % 8] ? pd[i][cyc % 8] : $urandom;
      pv[i][cyc % 8] = 1'b0;
    end
  endtask

  task automatic set_port(input int i, input int p, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      core_req[i] = r; core_we[i] = w; core_addr[i] = a; core_wdata[i] = d;
    end else begin
      dma_req[i] = r; dma_we[i] = w; dma_addr[i] = a; dma_wdata[i] = d;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_port(i, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_port(i, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // One access on one port, held until done or a 20-cycle budget expires
  task automatic txn(input int i, input int p, input logic w, input logic [31:0] a,
                     input logic [31:0] d, output int lat, output logic [31:0] rd,
                     output int en_n, output logic [31:0] en_addr, output logic [31:0] st);
    int t0;
    t0 = cyc; lat = -1; en_n = 0; rd = 'x; en_addr = 'x; st = 'x;
    set_port(i, p, 1'b1, w, a, d);
    for (int n = 0; n < 20 && lat < 0; n++) begin
      cycle();
      if (obs_me[i]) begin en_n++; en_addr = obs_ma[i]; end
      if ((p == 0) ? obs_cd[i] : obs_dd[i]) begin
        lat = cyc - 1 - t0;
        rd  = (p == 0) ? obs_cr[i] : obs_dr[i];
        st  = obs_st[i];
      end
    end
    set_port(i, p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Both ports request reads continuously until each has completed its quota
  task automatic run_both(input int i, input int nc, input int nd, input int budget,
                          output int order [$]);
    int cc, dc;
    cc = 0; dc = 0;
    order = {};
    set_port(i, 0, nc > 0, 1'b0, 32'h4, 32'h0);
    set_port(i, 1, nd > 0, 1'b0, 32'h8, 32'h0);
    for (int n = 0; n < budget && (cc < nc || dc < nd); n++) begin
      cycle();
      if (obs_cd[i]) begin order.push_back(0); cc++; end
      if (obs_dd[i]) begin order.push_back(1); dc++; end
      core_req[i] = (cc < nc);
      dma_req[i]  = (dc < nd);
    end
    core_req[i] = 1'b0;
    dma_req[i]  = 1'b0;
  endtask

  initial begin
    int          lat, en_n, q [$], nd10, t0;
    logic [31:0] rd, en_addr, st;
    int          exp3 [4];
    bit          pend [2][2];
    logic        dn;

    vectors = 0; miscompares = 0; cyc = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_port(i, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_port(i, 1, 1'b0, 1'b0, 32'h0, 32'h0);
      mem_rdata[i] = '0;
      for (int w = 0; w < 64; w++) bmem[i][w] = (32'(i + 1) << 28) | 32'(w);
      bmem[i][4] = 32'hDEADBEEF;
      for (int w = 0; w < 64; w++) mmem[i][w] = bmem[i][w];
      model_reset(i);
      pend[i][0] = 1'b0; pend[i][1] = 1'b0;
    end

    tbl[0] = '{0, 1, 1'b1, 32'h40, 32'h12345678, 4, 32'h0};
    tbl[1] = '{0, 0, 1'b0, 32'h40, 32'h0,        4, 32'h12345678};
    tbl[2] = '{1, 1, 1'b1, 32'h3C, 32'hCAFEF00D, 2, 32'h0};
    tbl[3] = '{1, 0, 1'b0, 32'h3C, 32'h0,        2, 32'hCAFEF00D};
    tbl[4] = '{1, 1, 1'b0, 32'h10, 32'h0,        2, 32'hDEADBEEF};
    tbl[5] = '{0, 0, 1'b1, 32'h00, 32'hFFFFFFFF, 4, 32'h0};
    tbl[6] = '{0, 1, 1'b0, 32'h00, 32'h0,        4, 32'hFFFFFFFF};
    tbl[7] = '{0, 0, 1'b0, 32'hFC, 32'h0,        4, 32'h1000003F};

    cycle();
    rst = 1'b0;
    cycle();

    // Single-cycle-latency core read straight after reset
    txn(1, 0, 1'b0, 32'h10, 32'h0, lat, rd, en_n, en_addr, st);
    chk("t1 latency", 32'(lat), 32'd2);
    chk("t1 rdata", rd, 32'hDEADBEEF);
    chk("t1 mem_en cycles", 32'(en_n), 32'd1);
    chk("t1 mem_addr", en_addr, 32'h10);
    chk("t1 stall_cnt", st, 32'd2);
    cycle();

    for (int k = 0; k < 8; k++) begin
      txn(tbl[k].inst, tbl[k].port, tbl[k].we, tbl[k].addr, tbl[k].wdata, lat, rd, en_n, en_addr, st);
      chk($sformatf("tbl%0d latency", k), 32'(lat), 32'(tbl[k].exp_lat));
      chk($sformatf("tbl%0d rdata", k), rd, tbl[k].exp_rd);
      chk($sformatf("tbl%0d mem_en cycles", k), 32'(en_n), 32'd1);
      chk($sformatf("tbl%0d mem_addr", k), en_addr, tbl[k].addr);
      cycle();
    end

    // Round-robin alternation on simultaneous held requests
    do_reset();
    exp3 = '{0, 1, 0, 1};
    run_both(0, 2, 2, 40, q);
    chk("rr order length", 32'(q.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr order[%0d]", k), 32'(q[k]), 32'(exp3[k]));
    cycle();

    // Core priority: DMA only gets in once the core stops asking
    do_reset();
    run_both(1, 10, 1, 60, q);
    nd10 = 0;
    for (int k = 0; k < 10 && k < q.size(); k++) nd10 += q[k];
    chk("prio order length", 32'(q.size()), 32'd11);
    chk("prio dma grants among first 10", 32'(nd10), 32'd0);
    chk("prio last grant is dma", 32'(q[10]), 32'd1);
    cycle();

    // Reset in the second WAIT cycle aborts the access
    do_reset();
    set_port(0, 0, 1'b1, 1'b0, 32'h20, 32'h0);
    cycle(); cycle(); cycle();
    rst = 1'b1;
    set_port(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    chk("abort mem_en", 32'(obs_me[0]), 32'd0);
    chk("abort mem_addr", obs_ma[0], 32'h0);
    chk("abort core_done", 32'(obs_cd[0]), 32'd0);
    chk("abort core_rdata", obs_cr[0], 32'h0);
    chk("abort stall_cnt", obs_st[0], 32'h0);
    cycle();
    rst = 1'b0;
    en_n = 0;
    for (int n = 0; n < 6; n++) begin cycle(); en_n += int'(obs_cd[0]); end
    chk("abort no late done", 32'(en_n), 32'd0);
    txn(0, 0, 1'b0, 32'h20, 32'h0, lat, rd, en_n, en_addr, st);
    chk("after abort latency", 32'(lat), 32'd4);
    chk("after abort rdata", rd, 32'h10000008);
    cycle();

    // Address change during WAIT is ignored
    set_port(0, 0, 1'b1, 1'b0, 32'h8, 32'h0);
    t0 = cyc; lat = -1; rd = 'x; en_addr = 'x;
    for (int n = 0; n < 20 && lat < 0; n++) begin
      cycle();
      if (cyc - t0 == 2) core_addr[0] = 32'hC;
      if (obs_cd[0]) begin lat = cyc - 1 - t0; rd = obs_cr[0]; en_addr = obs_ma[0]; end
    end
    set_port(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("addr change latency", 32'(lat), 32'd4);
    chk("addr change rdata", rd, 32'h10000002);
    chk("addr change mem_addr", en_addr, 32'h8);
    cycle();

    // Random traffic on both arbiters, requesters obeying the hold/drop handshake
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) begin
          dn = (p == 0) ? m_cd[i] : m_dd[i];
          if (pend[i][p] && dn) begin
            pend[i][p] = 1'b0;
            set_port(i, p, 1'b0, 1'b0, 32'h0, 32'h0);
          end
          if (!pend[i][p] && ($urandom % 4 == 0)) begin
            pend[i][p] = 1'b1;
            set_port(i, p, 1'b1, 1'($urandom % 2), 32'(($urandom % 64) * 4), $urandom);
          end
        end
      end
      cycle();
    end
    for (int i = 0; i < 2; i++) begin
      set_port(i, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_port(i, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    for (int n = 0; n < 8; n++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
